// File: rtl/pl_exception_redirect.sv
// Exception redirect and flush controller.
// Turns an exception request or an ERET into a one-cycle PC redirect plus
// FLUSH_CYCLES cycles of flush on the IF/ID, ID/EX and EX/MEM registers.
// It also tracks handler residency and latches a double fault into a sticky halt.
module pl_exception_redirect #(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        exc_req,
    input  logic        exc_undefined,
    input  logic [31:0] exc_vector,
    input  logic [31:0] epc,
    input  logic        eret,
    output logic        pc_redirect,
    output logic [31:0] pc_target,
    output logic        flush_if,
    output logic        flush_id,
    output logic        flush_ex,
    output logic [1:0]  cause,
    output logic        in_handler,
    output logic        halted
);

    localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        EXC_FLUSH = 3'd1,
        HANDLER   = 3'd2,
        RET_FLUSH = 3'd3,
        HALT      = 3'd4
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             first_q;
    logic             take_exc;
    logic             take_ret;
    logic             in_flush;

    assign in_flush = (state_q == EXC_FLUSH) || (state_q == RET_FLUSH);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. Flush states count down regardless of enable, and
    // requests arriving while squashing are deliberately dropped.
    always_comb begin
        state_d  = state_q;
        take_exc = 1'b0;
        take_ret = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable && exc_req) begin
                    take_exc = 1'b1;
                    state_d  = EXC_FLUSH;
                end
            end
            EXC_FLUSH: begin
                if (cnt_q == CNT_ONE) begin
                    state_d = HANDLER;
                end
            end
            HANDLER: begin
                if (enable && exc_req) begin
                    state_d = HALT;
                end else if (enable && eret) begin
                    take_ret = 1'b1;
                    state_d  = RET_FLUSH;
                end
            end
            RET_FLUSH: begin
                if (cnt_q == CNT_ONE) begin
                    state_d = IDLE;
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Redirect target, cause, flush counter and first-cycle flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_target <= 32'h0;
            cause     <= 2'b00;
            cnt_q     <= CNT_ZERO;
            first_q   <= 1'b0;
        end else begin
            first_q <= take_exc || take_ret;
            if (take_exc) begin
                pc_target <= exc_vector;
                cause     <= exc_undefined ? 2'b01 : 2'b10;
                cnt_q     <= CNT_LOAD;
            end else if (take_ret) begin
                pc_target <= epc;
                cnt_q     <= CNT_LOAD;
            end else if (in_flush && (cnt_q != CNT_ZERO)) begin
                cnt_q <= cnt_q - CNT_ONE;
            end
            if ((state_q == RET_FLUSH) && (state_d == IDLE)) begin
                cause <= 2'b00;
            end
        end
    end

    // Output decode from registered state and the registered first-cycle flag.
    always_comb begin
        pc_redirect = 1'b0;
        flush_if    = 1'b0;
        flush_id    = 1'b0;
        flush_ex    = 1'b0;
        in_handler  = 1'b0;
        halted      = 1'b0;
        case (state_q)
            EXC_FLUSH: begin
                pc_redirect = first_q;
                flush_if    = 1'b1;
                flush_id    = 1'b1;
                flush_ex    = 1'b1;
            end
            HANDLER: begin
                in_handler = 1'b1;
            end
            RET_FLUSH: begin
                pc_redirect = first_q;
                flush_if    = 1'b1;
                flush_id    = 1'b1;
                flush_ex    = 1'b1;
                in_handler  = 1'b1;
            end
            HALT: begin
                flush_if   = 1'b1;
                flush_id   = 1'b1;
                flush_ex   = 1'b1;
                in_handler = 1'b1;
                halted     = 1'b1;
            end
            default: begin
                pc_redirect = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/pl_exception_redirect.md
# pl_exception_redirect

Sequential redirect and flush controller placed directly downstream of the pipeline's exception-detection logic. It consumes the exception request, handler vector, cause and saved EPC, then drives PC redirection and per-stage flush pulses into the fetch, decode and execute pipeline registers. It tracks whether the core is executing a handler, handles the return-from-exception (ERET) redirect back to the EPC, and traps a nested exception (double fault) into a terminal halt.

## Interface
- FLUSH_CYCLES, 2: number of consecutive cycles `flush_*` stays asserted per redirect; legal range 1..7.
- clk  in  1  pipeline clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high; forces all state and outputs to reset values immediately.
- enable  in  1  pipeline advance (high means not stalled); gates sampling of `exc_req` and `eret`.
- exc_req  in  1  exception raised by the instruction in EX (undefined instruction or overflow).
- exc_undefined  in  1  cause qualifier; 1 = undefined instruction, 0 = overflow. Valid only with `exc_req`.
- exc_vector  in  32  handler entry address for the current exception.
- epc  in  32  saved exception PC; valid whenever `in_handler` is 1.
- eret  in  1  return-from-exception decoded in EX.
- pc_redirect  out  1  one-cycle pulse; PC mux selects `pc_target` this cycle.
- pc_target  out  32  redirect address, registered.
- flush_if, flush_id, flush_ex  out  1 each  squash IF/ID, ID/EX and EX/MEM register contents.
- cause  out  2  00 none, 01 undefined, 10 overflow. 11 is never driven.
- in_handler  out  1  the core is executing an exception handler.
- halted  out  1  double fault; sticky until reset.

## Operation
- The FSM has five states: IDLE, EXC_FLUSH, HANDLER, RET_FLUSH, HALT. The reset state is IDLE.
- **IDLE.** When `enable && exc_req`:
  - Load `pc_target <= exc_vector`.
  - Load `cause <= exc_undefined ? 01 : 10`.
  - Load the counter with FLUSH_CYCLES.
  - Go to EXC_FLUSH.
  - `eret` is ignored in IDLE (no redirect). If `exc_req` and `eret` arrive together in IDLE, the exception path is taken.
- **EXC_FLUSH.**
  - All three `flush_*` are 1.
  - `pc_redirect` is 1 only on the first cycle in the state.
  - The counter decrements every cycle, independent of `enable`. When it reaches 1, go to HANDLER.
  - `exc_req` and `eret` are ignored, because those instructions are being squashed.
- **HANDLER.**
  - `in_handler` = 1 and `cause` is held.
  - `enable && exc_req` goes to HALT. This check has priority over `eret` when both are asserted.
  - Otherwise, `enable && eret`:
    - Load `pc_target <= epc`.
    - Load the counter with FLUSH_CYCLES.
    - Go to RET_FLUSH.
- **RET_FLUSH.**
  - Same flush and pulse behaviour as EXC_FLUSH.
  - `in_handler` stays 1 throughout.
  - When the counter reaches 1, go to IDLE and clear `cause` to 00 on that transition.
- **HALT.**
  - `halted` = 1, all `flush_*` = 1, `pc_redirect` = 0, `in_handler` = 1, `cause` held.
  - The only exit is `reset`.
- **Registered outputs.** All outputs are registered, or decoded from the registered state plus a registered first-cycle flag. None is combinational from inputs.
- **Counter.** Width is $clog2(FLUSH_CYCLES+1). It never underflows, and it is reloaded on every flush entry.

## Timing
- **Reset values.** State IDLE; `pc_redirect`, all `flush_*`, `in_handler` and `halted` are 0; `pc_target` = 0; `cause` = 00; counter = 0.
- **Latency.** With `exc_req` sampled at edge N:
  - `pc_redirect` and the flushes are high in cycle N+1.
  - The flushes stay high through cycle N+FLUSH_CYCLES.
  - HANDLER is entered at edge N+FLUSH_CYCLES.
- **ERET.** ERET latency is identical. IDLE is re-entered at edge N+FLUSH_CYCLES.
- **Stall with `enable` low.** The FSM holds in IDLE and HANDLER, and `exc_req`/`eret` are not sampled. The flush states still count down.
- **Back-to-back.** `exc_req` on the first HANDLER cycle is honoured and goes straight to HALT. `exc_req` on the last flush cycle is ignored.
- **Reset mid-operation.** Reset asserted during any state (including a flush) clears everything asynchronously. No residual pulse follows deassertion.

## Test plan
- **Overflow exception.**
  - Stimulus: FLUSH_CYCLES=2. In IDLE, `exc_req`=1, `exc_undefined`=0, `exc_vector`=0x80000180.
  - Required: next cycle `pc_redirect`=1 and `pc_target`=0x80000180; flushes high for 2 cycles; `cause`=10; then `in_handler`=1.
- **ERET return.**
  - Stimulus: in HANDLER, `epc`=0x00400010 and `eret`=1.
  - Required: one `pc_redirect` pulse with `pc_target`=0x00400010; flushes high for 2 cycles; then `in_handler`=0 and `cause`=00.
- **Double fault.**
  - Stimulus: in HANDLER, `exc_req`=1 and `eret`=1 in the same cycle, `exc_undefined`=1.
  - Required: HALT with `halted`=1 and flushes held high. There is no `pc_redirect`, and the state persists for 20 cycles until reset.
- **Stall.**
  - Stimulus: `exc_req`=1 with `enable`=0 for 3 cycles, then `enable`=1.
  - Required: no response during the stall; redirect occurs exactly 1 cycle after `enable` rises. Separately, `enable` dropping during EXC_FLUSH does not extend the flush beyond 2 cycles.
- **Reset mid-flush.**
  - Stimulus: assert `reset` in the first EXC_FLUSH cycle, between clock edges.
  - Required: all outputs drop to reset values immediately; after release the block is in IDLE with `cause`=00.
- **Spurious ERET in IDLE.**
  - Stimulus: `eret`=1 with `exc_req`=0 while in IDLE.
  - Required: no `pc_redirect`, no flush, and the state stays IDLE.
